// File: rtl/adc_fft_pkg.sv
// Shared FSM encoding, width helper and default derived widths for the ADC-to-FFT loader.
package adc_fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int ceil_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int DEF_POINTS     = 32;
    localparam int DEF_FIFO_DEPTH = 64;
    localparam int CNT_W          = ceil_log2(DEF_POINTS) + 1;
    localparam int FIFO_AW        = ceil_log2(DEF_FIFO_DEPTH);

endpackage

// File: rtl/adc_fft_fifo.sv
// Single-clock sample FIFO with occupancy count; a pop in the same cycle frees room for a push when full.
module adc_fft_fifo
    import adc_fft_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 64,
    parameter int AW    = ceil_log2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] popData_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             doPush;
    logic             doPop;

    // DEPTH is a power of two, so the count MSB alone marks a full FIFO.
    assign full_o    = count_q[AW];
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign popData_o = mem_q[rdPtr_q];
    assign doPop     = pop_i && !empty_o;
    assign doPush    = push_i && (!full_o || doPop);

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= pushData_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PTR_ONE;
            if (doPop)  rdPtr_q <= rdPtr_q + PTR_ONE;
            if (doPush && !doPop)      count_q <= count_q + CNT_ONE;
            else if (doPop && !doPush) count_q <= count_q - CNT_ONE;
        end
    end

endmodule

// File: rtl/adc_fft_loader.sv
// Captures one ADC channel, converts offset-binary to two's complement and streams
// POINTS-word frames into the COREFFT load port, paced by BUF_READY.
module adc_fft_loader
    import adc_fft_pkg::*;
#(
    parameter int ADC_BITS   = 10,
    parameter int WIDTH      = 10,
    parameter int POINTS     = 32,
    parameter int CH_BITS    = 5,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [CH_BITS-1:0]  chan_sel,
    input  logic [ADC_BITS-1:0] adc_data,
    input  logic [CH_BITS-1:0]  adc_chan,
    input  logic                adc_valid,
    input  logic                fft_buf_ready,
    output logic [WIDTH-1:0]    fft_datai_re,
    output logic [WIDTH-1:0]    fft_datai_im,
    output logic                fft_datai_valid,
    output logic                frame_done,
    output logic                frame_abort,
    output logic                ovf,
    input  logic                ovf_clr,
    output logic [15:0]         frame_cnt
);

    localparam int cntW   = ceil_log2(POINTS) + 1;
    localparam int fifoAw = ceil_log2(FIFO_DEPTH);
    localparam logic [cntW-1:0]     LAST_IDX = cntW'(POINTS - 1);
    localparam logic [cntW-1:0]     CNT_ONE  = cntW'(1);
    localparam logic [ADC_BITS-1:0] MID      = {1'b1, {(ADC_BITS - 1){1'b0}}};

    state_e              state_q;
    logic [CH_BITS-1:0]  chan_q;
    logic [cntW-1:0]     wordCnt_q;
    logic [WIDTH-1:0]    re_q;
    logic                valid_q;
    logic                done_q;
    logic                abort_q;
    logic                ovf_q;
    logic [15:0]         frameCnt_q;

    logic [ADC_BITS-1:0] flipped;
    logic [WIDTH-1:0]    conv;
    logic                capture;
    logic                pop;
    logic                ovfSet;
    logic [WIDTH-1:0]    fifoData;
    logic [fifoAw:0]     fifoCount;
    logic                fifoFull;
    logic                fifoEmpty;

    // Flipping the MSB subtracts mid-scale; the result is left-aligned into the FFT word.
    assign flipped = adc_data ^ MID;
    assign conv    = WIDTH'(flipped) << (WIDTH - ADC_BITS);
    assign capture = adc_valid && enable && (adc_chan == chan_q);
    assign pop     = (state_q == LOAD) && fft_buf_ready && !fifoEmpty;
    assign ovfSet  = capture && fifoFull && !pop;

    adc_fft_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (fifoAw)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (capture),
        .pushData_i (conv),
        .pop_i      (pop),
        .popData_o  (fifoData),
        .count_o    (fifoCount),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            chan_q     <= '0;
            wordCnt_q  <= '0;
            re_q       <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            ovf_q      <= 1'b0;
            frameCnt_q <= '0;
        end else begin
            valid_q <= pop;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            if (pop) re_q <= fifoData;
            if (ovfSet)       ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    chan_q <= chan_sel;
                    if (enable && fft_buf_ready && (fifoCount != '0)) state_q <= LOAD;
                end
                LOAD: begin
                    if (pop) begin
                        if (wordCnt_q == LAST_IDX) begin
                            done_q     <= 1'b1;
                            frameCnt_q <= frameCnt_q + 16'd1;
                            wordCnt_q  <= '0;
                            state_q    <= DRAIN;
                        end else begin
                            wordCnt_q <= wordCnt_q + CNT_ONE;
                        end
                    end else if (!fft_buf_ready) begin
                        // Losing BUF_READY before anything was issued is not an abort.
                        abort_q   <= (wordCnt_q != '0);
                        wordCnt_q <= '0;
                        state_q   <= IDLE;
                    end
                end
                DRAIN: begin
                    if (!fft_buf_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fft_datai_re    = re_q;
    assign fft_datai_im    = '0;
    assign fft_datai_valid = valid_q;
    assign frame_done      = done_q;
    assign frame_abort     = abort_q;
    assign ovf             = ovf_q;
    assign frame_cnt       = frameCnt_q;

endmodule

// File: tb/tb_adc_fft_loader.sv
// Randomized bench for adc_fft_loader: a queue model of captured samples and frame
// boundaries is compared against the word stream collected from the FFT load port.
module tb_adc_fft_loader;

    localparam int ADC_BITS   = 10;
    localparam int WIDTH      = 10;
    localparam int POINTS     = 32;
    localparam int CH_BITS    = 5;
    localparam int FIFO_DEPTH = 64;
    localparam logic [CH_BITS-1:0] SEL = 5'd3;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic [CH_BITS-1:0]  chan_sel;
    logic [ADC_BITS-1:0] adc_data;
    logic [CH_BITS-1:0]  adc_chan;
    logic                adc_valid;
    logic                fft_buf_ready;
    logic [WIDTH-1:0]    fft_datai_re;
    logic [WIDTH-1:0]    fft_datai_im;
    logic                fft_datai_valid;
    logic                frame_done;
    logic                frame_abort;
    logic                ovf;
    logic                ovf_clr;
    logic [15:0]         frame_cnt;

    always #5 clk = ~clk;

    adc_fft_loader #(
        .ADC_BITS   (ADC_BITS),
        .WIDTH      (WIDTH),
        .POINTS     (POINTS),
        .CH_BITS    (CH_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .chan_sel        (chan_sel),
        .adc_data        (adc_data),
        .adc_chan        (adc_chan),
        .adc_valid       (adc_valid),
        .fft_buf_ready   (fft_buf_ready),
        .fft_datai_re    (fft_datai_re),
        .fft_datai_im    (fft_datai_im),
        .fft_datai_valid (fft_datai_valid),
        .frame_done      (frame_done),
        .frame_abort     (frame_abort),
        .ovf             (ovf),
        .ovf_clr         (ovf_clr),
        .frame_cnt       (frame_cnt)
    );

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] expQ[$];
    logic [WIDTH-1:0] obsQ[$];
    logic             obsDoneQ[$];
    int abortCnt  = 0;
    int strayDone = 0;
    int imBad     = 0;
    int modelIdx  = 0;
    int expFrames = 0;

    // Collect every issued word with its frame_done flag, plus pulse and imaginary-part anomalies.
    always @(negedge clk) begin
        if (fft_datai_valid === 1'b1) begin
            obsQ.push_back(fft_datai_re);
            obsDoneQ.push_back(frame_done);
        end else if (frame_done !== 1'b0) begin
            strayDone++;
        end
        if (frame_abort === 1'b1) abortCnt++;
        if (fft_datai_im !== '0) imBad++;
    end

    function automatic logic [WIDTH-1:0] convert(input logic [ADC_BITS-1:0] d);
        logic [ADC_BITS-1:0] s;
        s = d - ADC_BITS'(1 << (ADC_BITS - 1));
        return WIDTH'(s) << (WIDTH - ADC_BITS);
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [CH_BITS-1:0] ch, input logic [ADC_BITS-1:0] d);
        adc_chan  = ch;
        adc_data  = d;
        adc_valid = 1'b1;
        if (enable && ch == SEL && expQ.size() < FIFO_DEPTH) expQ.push_back(convert(d));
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) tick();
        checks++;
        if ({fft_datai_valid, fft_datai_re, fft_datai_im} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data got valid=%b re=%h im=%h want all 0", fft_datai_valid, fft_datai_re, fft_datai_im);
        end
        checks++;
        if ({frame_done, frame_abort, ovf} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_flags got done=%b abort=%b ovf=%b want 0", frame_done, frame_abort, ovf);
        end
        checks++;
        if (frame_cnt !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_frame_cnt got %0d want 0", frame_cnt);
        end
        reset         = 1'b0;
        enable        = 1'b1;
        fft_buf_ready = 1'b1;
        repeat (8) tick();
        checks++;
        if (obsQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL idle_no_valid got %0d words want 0", obsQ.size());
        end
        fft_buf_ready = 1'b0;
        tick();
    endtask

    task automatic test_full_frame();
        logic [WIDTH-1:0] w, e;
        logic             dn, eDone;
        fft_buf_ready = 1'b1;
        tick();
        for (int i = 0; i < POINTS; i++) applyStimulus(SEL, ADC_BITS'(32'h200 + i));
        for (int c = 0; c < 200 && obsQ.size() < POINTS; c++) tick();
        checks++;
        if (obsQ.size() != POINTS) begin
            failures++;
            $display("[TB] FAIL frame_word_count got %0d want %0d", obsQ.size(), POINTS);
        end
        while (obsQ.size() > 0) begin
            w = obsQ.pop_front();
            dn = obsDoneQ.pop_front();
            e = (expQ.size() > 0) ? expQ.pop_front() : 'x;
            modelIdx++;
            eDone = (modelIdx == POINTS);
            if (eDone) begin modelIdx = 0; expFrames++; end
            checks++;
            if (w !== e || dn !== eDone) begin
                failures++;
                $display("[TB] FAIL frame_word got re=%h done=%b want re=%h done=%b", w, dn, e, eDone);
            end
        end
        checks++;
        if (frame_cnt !== 16'(expFrames)) begin
            failures++;
            $display("[TB] FAIL frame_cnt_1 got %0d want %0d", frame_cnt, expFrames);
        end
        // Samples arriving while BUF_READY stays high after a frame must wait in the FIFO.
        for (int i = 0; i < 3; i++) applyStimulus(SEL, ADC_BITS'($urandom_range(0, 1023)));
        repeat (10) tick();
        checks++;
        if (obsQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain_no_valid got %0d words want 0", obsQ.size());
        end
        fft_buf_ready = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_channel_filter();
        logic [WIDTH-1:0] w, e;
        logic             dn, eDone;
        int               need, n;
        need = POINTS - expQ.size();
        n = 0;
        fft_buf_ready = 1'b1;
        while (n < need) begin
            case ($urandom_range(0, 3))
                0: begin applyStimulus(SEL, 10'h3FF); n++; end
                1: applyStimulus(5'd4, 10'h000);
                2: applyStimulus(CH_BITS'($urandom_range(4, 31)), ADC_BITS'($urandom_range(0, 1023)));
                default: tick();
            endcase
        end
        for (int c = 0; c < 300 && obsQ.size() < POINTS; c++) tick();
        checks++;
        if (obsQ.size() != POINTS) begin
            failures++;
            $display("[TB] FAIL filter_word_count got %0d want %0d", obsQ.size(), POINTS);
        end
        while (obsQ.size() > 0) begin
            w = obsQ.pop_front();
            dn = obsDoneQ.pop_front();
            e = (expQ.size() > 0) ? expQ.pop_front() : 'x;
            modelIdx++;
            eDone = (modelIdx == POINTS);
            if (eDone) begin modelIdx = 0; expFrames++; end
            checks++;
            if (w !== e || dn !== eDone) begin
                failures++;
                $display("[TB] FAIL filter_word got re=%h done=%b want re=%h done=%b", w, dn, e, eDone);
            end
        end
        checks++;
        if (frame_cnt !== 16'(expFrames)) begin
            failures++;
            $display("[TB] FAIL frame_cnt_2 got %0d want %0d", frame_cnt, expFrames);
        end
        fft_buf_ready = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] w, e;
        logic             dn, eDone;
        for (int i = 0; i < FIFO_DEPTH; i++) applyStimulus(SEL, ADC_BITS'($urandom_range(0, 1023)));
        tick();
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_at_full got %b want 0", ovf);
        end
        for (int i = 0; i < 2; i++) applyStimulus(SEL, ADC_BITS'($urandom_range(0, 1023)));
        tick();
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_set got %b want 1", ovf);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_clear got %b want 0", ovf);
        end
        ovf_clr = 1'b1;
        applyStimulus(SEL, ADC_BITS'($urandom_range(0, 1023)));
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_set_wins got %b want 1", ovf);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        fft_buf_ready = 1'b1;
        for (int c = 0; c < 200 && obsQ.size() < POINTS; c++) tick();
        fft_buf_ready = 1'b0;
        repeat (2) tick();
        fft_buf_ready = 1'b1;
        for (int c = 0; c < 200 && obsQ.size() < FIFO_DEPTH; c++) tick();
        checks++;
        if (obsQ.size() != FIFO_DEPTH) begin
            failures++;
            $display("[TB] FAIL ovf_word_count got %0d want %0d", obsQ.size(), FIFO_DEPTH);
        end
        while (obsQ.size() > 0) begin
            w = obsQ.pop_front();
            dn = obsDoneQ.pop_front();
            e = (expQ.size() > 0) ? expQ.pop_front() : 'x;
            modelIdx++;
            eDone = (modelIdx == POINTS);
            if (eDone) begin modelIdx = 0; expFrames++; end
            checks++;
            if (w !== e || dn !== eDone) begin
                failures++;
                $display("[TB] FAIL ovf_word got re=%h done=%b want re=%h done=%b", w, dn, e, eDone);
            end
        end
        checks++;
        if (frame_cnt !== 16'(expFrames)) begin
            failures++;
            $display("[TB] FAIL frame_cnt_ovf got %0d want %0d", frame_cnt, expFrames);
        end
        fft_buf_ready = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_abort();
        logic [WIDTH-1:0] w, e;
        logic             dn, eDone;
        int               a0;
        for (int i = 0; i < 40; i++) applyStimulus(SEL, ADC_BITS'($urandom_range(0, 1023)));
        a0 = abortCnt;
        fft_buf_ready = 1'b1;
        for (int c = 0; c < 200 && obsQ.size() < 10; c++) tick();
        fft_buf_ready = 1'b0;
        repeat (4) tick();
        checks++;
        if (obsQ.size() != 10) begin
            failures++;
            $display("[TB] FAIL abort_word_count got %0d want 10", obsQ.size());
        end
        while (obsQ.size() > 0) begin
            w = obsQ.pop_front();
            dn = obsDoneQ.pop_front();
            e = (expQ.size() > 0) ? expQ.pop_front() : 'x;
            modelIdx++;
            eDone = (modelIdx == POINTS);
            if (eDone) begin modelIdx = 0; expFrames++; end
            checks++;
            if (w !== e || dn !== eDone) begin
                failures++;
                $display("[TB] FAIL abort_word got re=%h done=%b want re=%h done=%b", w, dn, e, eDone);
            end
        end
        modelIdx = 0;
        checks++;
        if (abortCnt - a0 != 1) begin
            failures++;
            $display("[TB] FAIL abort_pulse got %0d cycles want 1", abortCnt - a0);
        end
        checks++;
        if (frame_cnt !== 16'(expFrames)) begin
            failures++;
            $display("[TB] FAIL abort_frame_cnt got %0d want %0d", frame_cnt, expFrames);
        end
        for (int i = 0; i < 10; i++) applyStimulus(SEL, ADC_BITS'($urandom_range(0, 1023)));
        fft_buf_ready = 1'b1;
        for (int c = 0; c < 200 && obsQ.size() < POINTS; c++) tick();
        repeat (3) tick();
        checks++;
        if (obsQ.size() != POINTS) begin
            failures++;
            $display("[TB] FAIL post_abort_word_count got %0d want %0d", obsQ.size(), POINTS);
        end
        while (obsQ.size() > 0) begin
            w = obsQ.pop_front();
            dn = obsDoneQ.pop_front();
            e = (expQ.size() > 0) ? expQ.pop_front() : 'x;
            modelIdx++;
            eDone = (modelIdx == POINTS);
            if (eDone) begin modelIdx = 0; expFrames++; end
            checks++;
            if (w !== e || dn !== eDone) begin
                failures++;
                $display("[TB] FAIL post_abort_word got re=%h done=%b want re=%h done=%b", w, dn, e, eDone);
            end
        end
        checks++;
        if (strayDone != 0) begin
            failures++;
            $display("[TB] FAIL stray_done got %0d want 0", strayDone);
        end
        fft_buf_ready = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_frame();
        logic [WIDTH-1:0] w, e;
        logic             dn, eDone;
        for (int i = 0; i < 30; i++) applyStimulus(SEL, ADC_BITS'($urandom_range(0, 1023)));
        fft_buf_ready = 1'b1;
        for (int c = 0; c < 200 && obsQ.size() < 20; c++) tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({fft_datai_valid, fft_datai_re, frame_done, frame_abort, ovf, frame_cnt} !== '0) begin
            failures++;
            $display("[TB] FAIL mid_reset_outputs got valid=%b re=%h done=%b abort=%b ovf=%b cnt=%0d want 0",
                     fft_datai_valid, fft_datai_re, frame_done, frame_abort, ovf, frame_cnt);
        end
        checks++;
        if (obsQ.size() != 20) begin
            failures++;
            $display("[TB] FAIL mid_reset_word_count got %0d want 20", obsQ.size());
        end
        while (obsQ.size() > 0) begin
            w = obsQ.pop_front();
            dn = obsDoneQ.pop_front();
            e = (expQ.size() > 0) ? expQ.pop_front() : 'x;
            modelIdx++;
            eDone = (modelIdx == POINTS);
            checks++;
            if (w !== e || dn !== eDone) begin
                failures++;
                $display("[TB] FAIL mid_reset_word got re=%h done=%b want re=%h done=%b", w, dn, e, eDone);
            end
        end
        expQ.delete();
        modelIdx  = 0;
        expFrames = 0;
        reset = 1'b0;
        repeat (8) tick();
        checks++;
        if (obsQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL fifo_empty_after_reset got %0d words want 0", obsQ.size());
        end
        for (int i = 0; i < POINTS; i++) applyStimulus(SEL, ADC_BITS'($urandom_range(0, 1023)));
        for (int c = 0; c < 200 && obsQ.size() < POINTS; c++) tick();
        checks++;
        if (obsQ.size() != POINTS) begin
            failures++;
            $display("[TB] FAIL after_reset_word_count got %0d want %0d", obsQ.size(), POINTS);
        end
        while (obsQ.size() > 0) begin
            w = obsQ.pop_front();
            dn = obsDoneQ.pop_front();
            e = (expQ.size() > 0) ? expQ.pop_front() : 'x;
            modelIdx++;
            eDone = (modelIdx == POINTS);
            if (eDone) begin modelIdx = 0; expFrames++; end
            checks++;
            if (w !== e || dn !== eDone) begin
                failures++;
                $display("[TB] FAIL after_reset_word got re=%h done=%b want re=%h done=%b", w, dn, e, eDone);
            end
        end
        checks++;
        if (frame_cnt !== 16'(expFrames)) begin
            failures++;
            $display("[TB] FAIL after_reset_frame_cnt got %0d want %0d", frame_cnt, expFrames);
        end
        checks++;
        if (imBad != 0) begin
            failures++;
            $display("[TB] FAIL imag_zero got %0d nonzero cycles want 0", imBad);
        end
        fft_buf_ready = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        reset         = 1'b1;
        enable        = 1'b0;
        chan_sel      = SEL;
        adc_data      = '0;
        adc_chan      = '0;
        adc_valid     = 1'b0;
        fft_buf_ready = 1'b0;
        ovf_clr       = 1'b0;
        test_reset();
        test_full_frame();
        test_channel_filter();
        test_overflow();
        test_abort();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
